// File: rtl/bus_interconnect.sv
`timescale 1ns/1ps
// bus_interconnect
// Single-master address-decoded bus fabric for the aq32 core.
// Each slave port is either a handshake slave (supplies its own wait) or a
// synchronous-read slave (registered read, the fabric inserts one wait cycle).
// Unmapped addresses complete immediately with an error. Accesses that wait
// too long are force-terminated with an error. The first error is held in a
// sticky capture register until software clears it.
module bus_interconnect #(
    parameter int                       N_SLAVES = 6,
    parameter logic [32*N_SLAVES-1:0]   SLV_BASE = {32'hFFFFF800, 32'hFF300000, 32'hFF200000,
                                                    32'hFF100000, 32'hFF000000, 32'hFFF00000},
    parameter logic [32*N_SLAVES-1:0]   SLV_MASK = {32'hFFFFF800, 32'hFFFFC000, 32'hFFFFC000,
                                                    32'hFFFFF800, 32'hFFFFF000, 32'hFFF80000},
    parameter logic [N_SLAVES-1:0]      SYNC_RD  = 6'b111110,
    parameter int                       TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        reset,

    // master side
    input  logic [31:0]                 m_addr,
    input  logic [31:0]                 m_wrdata,
    input  logic [3:0]                  m_bytesel,
    input  logic                        m_wren,
    input  logic                        m_strobe,
    output logic                        m_wait,
    output logic [31:0]                 m_rddata,
    output logic                        m_err,

    // slave side
    output logic [N_SLAVES-1:0]         s_strobe,
    input  logic [N_SLAVES-1:0]         s_wait,
    input  logic [32*N_SLAVES-1:0]      s_rddata,

    // error capture
    output logic                        err_valid,
    output logic [31:0]                 err_addr,
    output logic                        err_timeout,
    input  logic                        err_clr
);

    localparam int          SEL_W     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // wait_cnt value at which a still-waiting access is abandoned
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    // Access tracking: IDLE means the next strobed cycle is the first cycle
    // of an access; WAITING means the previous cycle was a stalled cycle of
    // the same access.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAITING = 1'b1
    } acc_state_t;

    acc_state_t             state_reg;
    acc_state_t             state_next;
    logic [15:0]            wait_cnt_reg;
    logic [15:0]            wait_cnt_next;

    logic                   err_valid_reg;
    logic                   err_valid_next;
    logic [31:0]            err_addr_reg;
    logic [31:0]            err_addr_next;
    logic                   err_timeout_reg;
    logic                   err_timeout_next;

    logic [N_SLAVES-1:0]    hit;
    logic [31:0]            slv_rddata [N_SLAVES];
    logic [SEL_W-1:0]       sel;
    logic                   any_hit;
    logic                   bus_live;
    logic                   active;
    logic                   first;
    logic                   wait_raw;
    logic                   timeout;
    logic                   decode_err;
    logic                   pass_through;

    // Write data and byte enables go straight to the slaves outside this block.
    logic                   unused_master_bits;
    assign unused_master_bits = ^{m_wrdata, m_bytesel};

    // ------------------------------------------------------------------
    // Per-port address decode, read-data unpacking and strobe generation
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_port
            assign hit[gi]        = (m_addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
            assign slv_rddata[gi] = s_rddata[32*gi +: 32];
            assign s_strobe[gi]   = pass_through && (sel == SEL_W'(gi));
        end
    endgenerate

    assign any_hit = |hit;

    // Priority encoder: the lowest-index hitting port owns the access.
    always_comb begin
        sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    // Reset forces every master-facing and slave-facing output to idle,
    // even between clock edges.
    assign bus_live = m_strobe && !reset;
    assign active   = (state_reg == ST_WAITING);
    assign first    = m_strobe && !active;

    // Raw wait request from the selected slave before timeout override.
    always_comb begin
        wait_raw = 1'b0;
        if (bus_live && any_hit) begin
            if (SYNC_RD[sel]) begin
                // registered-read slaves need exactly one stall on reads
                wait_raw = !m_wren && first;
            end else begin
                wait_raw = s_wait[sel];
            end
        end
    end

    assign timeout      = active && wait_raw && (wait_cnt_reg == WAIT_LAST);
    assign decode_err   = bus_live && !any_hit;
    assign pass_through = bus_live && any_hit && !timeout;

    // Master-side response.
    assign m_wait   = wait_raw && !timeout;
    assign m_err    = decode_err || timeout;
    assign m_rddata = pass_through ? slv_rddata[sel] : 32'h0;

    // ------------------------------------------------------------------
    // Access state and wait counter
    // ------------------------------------------------------------------

    // Next-state logic: remain WAITING only while the master is stalled.
    always_comb begin
        state_next    = ST_IDLE;
        wait_cnt_next = 16'h0;
        if (m_strobe && m_wait) begin
            state_next    = ST_WAITING;
            wait_cnt_next = wait_cnt_reg + 16'h1;
        end
    end

    // State register and consecutive-wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 16'h0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error capture
    // ------------------------------------------------------------------

    // A new error is captured when nothing is held, or when the held error
    // is being cleared in the same cycle (the new error wins over the clear).
    always_comb begin
        err_valid_next   = err_valid_reg;
        err_addr_next    = err_addr_reg;
        err_timeout_next = err_timeout_reg;
        if (m_err && (!err_valid_reg || err_clr)) begin
            err_valid_next   = 1'b1;
            err_addr_next    = m_addr;
            err_timeout_next = timeout;
        end else if (err_clr) begin
            err_valid_next   = 1'b0;
        end
    end

    // Capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_valid_reg   <= 1'b0;
            err_addr_reg    <= 32'h0;
            err_timeout_reg <= 1'b0;
        end else begin
            err_valid_reg   <= err_valid_next;
            err_addr_reg    <= err_addr_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    assign err_valid   = err_valid_reg;
    assign err_addr    = err_addr_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised single-master CPU bus interconnect for the aq32 core.
- Replaces the hand-written strobe, wait and read-data decode in the top level with N address-decoded slave ports. Each port is either a handshake slave (drives its own wait) or a synchronous-read slave (1-cycle registered read; the interconnect generates the wait).
- Adds things the current decode lacks: decode-error response for unmapped addresses, a bus timeout, and a sticky error-capture register.
- Sits between the cpu bus port and the memory/peripheral blocks (sram_ctrl, bootrom, video RAMs, video IO).

Parameters:
- N_SLAVES, 6, number of slave ports (1..16).
- SLV_BASE, {6 x 32-bit} = FFFFF800,FF300000,FF200000,FF100000,FF000000,FFF00000 (port 5..0), flattened base addresses, port i at bits [32i+31:32i].
- SLV_MASK, {6 x 32-bit} = FFFFF800,FFFFC000,FFFFC000,FFFFF800,FFFFF000,FFF80000, flattened decode masks, same packing.
- SYNC_RD, 6'b111110, bit i=1: port i is a synchronous-read slave; bit i=0: handshake slave using s_wait[i].
- TIMEOUT, 255, maximum consecutive wait cycles before forced termination (2..65535).

Ports:
- clk  in  1  system clock (28.63636 MHz).
- reset  in  1  asynchronous, active-high reset.
- m_addr  in  32  master byte address.
- m_wrdata  in  32  master write data (passed to slaves externally; not used here).
- m_bytesel  in  4  byte enables (passed to slaves externally; not used here).
- m_wren  in  1  1 = write, 0 = read.
- m_strobe  in  1  access request.
- m_wait  out  1  stall the master; combinational.
- m_rddata  out  32  read data; combinational.
- m_err  out  1  bus error on the completing cycle; combinational.
- s_strobe  out  N_SLAVES  one-hot slave select.
- s_wait  in  N_SLAVES  slave wait; ignored for SYNC_RD ports.
- s_rddata  in  32*N_SLAVES  flattened slave read data.
- err_valid  out  1  sticky error-captured flag.
- err_addr  out  32  address of the first captured error.
- err_timeout  out  1  captured error type: 1 = timeout, 0 = decode.
- err_clr  in  1  synchronous clear of err_valid.

Behaviour:
- Decode: hit[i] = (m_addr & MASK_i) == BASE_i. The lowest-index hit wins. sel is valid only when m_strobe=1 and at least one hit.
- Access handshake: the master holds addr, wren and wrdata stable while m_wait=1. An access completes on a cycle with m_strobe=1 and m_wait=0.
- State flag `active`:
  - Set after any cycle with m_strobe=1 and m_wait=1.
  - Cleared on completion or when m_strobe=0.
  - `first` = m_strobe && !active.
- Raw wait (wait_raw):
  - Handshake port: s_wait[sel].
  - SYNC_RD port, read: first (exactly one wait cycle; data is taken from s_rddata[sel] on the second cycle).
  - SYNC_RD port, write: 0.
- Unmapped address (m_strobe=1, no hit): s_strobe=0, m_wait=0, m_err=1, m_rddata=0, in the same cycle (0-latency error).
- Timeout:
  - wait_cnt (16 bit) resets to 0 and clears whenever active=0 or on completion. It increments on each cycle with wait_raw=1.
  - On the cycle where active=1, wait_raw=1 and wait_cnt == TIMEOUT-1: m_wait=0, m_err=1, m_rddata=0, and s_strobe is forced to 0 that cycle.
  - The slave is abandoned; slaves must tolerate a strobe drop.
- Normal path: m_wait = wait_raw, m_err = 0, m_rddata = s_rddata[sel]. m_rddata = 0 when m_strobe=0.
- s_strobe[i] = m_strobe && sel==i, except the timeout and reset cases above.
- Error capture:
  - On any cycle with m_err=1 and err_valid=0: err_valid <= 1, err_addr <= m_addr, err_timeout <= timeout flag.
  - Later errors do not overwrite the capture.
  - err_clr=1 clears err_valid. If an error occurs in the same cycle as err_clr, the capture wins: err_valid=1 with the new address.
- Reset (asynchronous, active-high):
  - active=0, wait_cnt=0, err_valid=0, err_addr=0, err_timeout=0.
  - While reset=1: s_strobe=0, m_wait=0, m_err=0, m_rddata=0.
  - Reset mid-access abandons the access; after release the access restarts as `first`.
- Back-to-back: a new access on the cycle after completion is treated as `first`. A SYNC_RD read therefore always costs 2 cycles, including consecutive reads to the same address.

Test Plan:
- Bootrom read at FFFFF804 (port 5, SYNC_RD) -> cycle 0: s_strobe=6'b100000, m_wait=1; cycle 1: m_wait=0, m_rddata = s_rddata port 5 = 0x12345678, m_err=0.
- Write to FF200010 (port 3, SYNC_RD) -> s_strobe=6'b001000, m_wait=0 in the first cycle.
- SRAM read at FFF00040 with s_wait[0] high for 3 cycles -> m_wait=1 for 3 cycles, completes on the 4th with s_rddata port 0; err_valid stays 0.
- Access to 00001000 (unmapped) -> same cycle: m_err=1, m_wait=0, m_rddata=0, s_strobe=0; next cycle err_valid=1, err_addr=00001000, err_timeout=0.
- TIMEOUT=8, s_wait[0] stuck at 1 -> m_wait=1 for 7 cycles; 8th cycle: m_err=1, s_strobe=0; err_timeout=1. Assert err_clr -> err_valid=0.
- Reset asserted mid-way through a SYNC_RD wait cycle -> outputs go to 0 immediately. After release with m_strobe held, the access restarts: wait 1 cycle, then data.
